// File: rtl/cnt_pkg.sv
// Shared definitions for the enable counter and its receiving-end checker.
// Holds the checker FSM encoding, the default bus width and the increment
// helper. The counter model and the checker both call the helper, so they
// agree on wrap semantics.
package cnt_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Computed on a 32-bit carrier. Callers truncate the result to their own
    // WIDTH, which yields the modulo-2^WIDTH wrap (all-ones + 1 -> 0).
    function automatic logic [31:0] next_cnt(input logic [31:0] prev, input logic en);
        return prev + {31'd0, en};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Generic W-bit saturating incrementer with a synchronous clear.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-low reset
//   clr   - synchronous clear to zero (lower priority than rst)
//   inc   - add one this cycle unless already all-ones
//   value - current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/cnt_checker.sv
// Receiving-end monitor for the free-running enable counter's cnt bus.
// Keeps a shadow copy of the last sample (cnt, en) and checks that each new
// sample equals previous cnt + previous en (mod 2^WIDTH). It is purely
// observational.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-low reset
//   en      - counter enable, same cycle as the counter sees it
//   cnt     - observed counter value
//   clr     - synchronous clear of err_cnt/fault; returns the FSM to INIT
//   err     - one-cycle pulse, the previous sample mismatched
//   wrap    - one-cycle pulse, the previous sample was a legal all-ones -> 0 wrap
//   err_cnt - saturating total of mismatches
//   fault   - sticky, high while in FAULT
//   state   - FSM state (debug)
module cnt_checker
    import cnt_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int ERR_W       = 8,
    parameter int FAULT_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt,
    input  logic             clr,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fault,
    output logic [1:0]       state
);

    state_t           state_q;
    logic [WIDTH-1:0] prev_cnt;
    logic             prev_en;
    logic [3:0]       miss;        // consecutive mismatches; FAULT_LIMIT tops out at 15

    logic [WIDTH-1:0] exp_cnt;
    logic             mismatch;
    logic             wrap_hit;
    logic [3:0]       miss_nxt;
    logic             err_inc;

    always_comb begin
        // NOTE: every combinational output gets a value first so no latch is inferred.
        exp_cnt  = WIDTH'(next_cnt(32'(prev_cnt), prev_en));
        mismatch = (cnt != exp_cnt);
        wrap_hit = (prev_cnt == {WIDTH{1'b1}}) && prev_en && (cnt == '0);
        miss_nxt = miss + 4'd1;
        err_inc  = (state_q == ST_TRACK) && mismatch;
    end

    // The error counter shares the clr priority, so a mismatch seen in a
    // clearing cycle is not counted.
    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (err_inc),
        .value (err_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            prev_cnt <= '0;
            prev_en  <= 1'b0;
            miss     <= '0;
            err      <= 1'b0;
            wrap     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            // The shadow registers sample in every state. After a mismatch the
            // observed value therefore becomes the next baseline.
            prev_cnt <= cnt;
            prev_en  <= en;
            err      <= 1'b0;
            wrap     <= 1'b0;
            if (clr) begin
                state_q <= ST_INIT;
                miss    <= '0;
                fault   <= 1'b0;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        state_q <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (mismatch) begin
                            err  <= 1'b1;
                            miss <= miss_nxt;
                            if (miss_nxt == 4'(FAULT_LIMIT)) begin
                                state_q <= ST_FAULT;
                                fault   <= 1'b1;
                            end
                        end else begin
                            miss <= '0;
                            wrap <= wrap_hit;
                        end
                    end
                    ST_FAULT: begin
                        fault <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_INIT;
                    end
                endcase
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cnt_checker.sv
module tb_cnt_checker;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] cnt;
    logic       clr;
    logic       err;
    logic       wrap;
    logic [7:0] err_cnt;
    logic       fault;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: remembers last sample, whether a baseline exists,
    // whether the checker has given up (faulted) and the running tallies.
    int m_prev, m_prev_en, m_have_base, m_faulted, m_miss, m_errs;
    int m_err, m_wrap, m_state;

    cnt_checker #(.WIDTH(8), .ERR_W(8), .FAULT_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .en(en), .cnt(cnt), .clr(clr),
        .err(err), .wrap(wrap), .err_cnt(err_cnt), .fault(fault), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_edge(input logic r, input logic c, input logic e, input logic [7:0] v);
        int expect_v;
        if (!r) begin
            m_prev = 0; m_prev_en = 0; m_have_base = 0; m_faulted = 0;
            m_miss = 0; m_errs = 0; m_err = 0; m_wrap = 0;
        end else begin
            m_err = 0;
            m_wrap = 0;
            if (c) begin
                m_errs = 0; m_miss = 0; m_faulted = 0; m_have_base = 0;
            end else if (m_faulted != 0) begin
                // frozen until clr or reset
            end else if (m_have_base == 0) begin
                m_have_base = 1;
            end else begin
                expect_v = (m_prev + m_prev_en) % 256;
                if (int'(v) != expect_v) begin
                    m_err = 1;
                    if (m_errs < 255) m_errs++;
                    m_miss++;
                    if (m_miss == 4) m_faulted = 1;
                end else begin
                    m_miss = 0;
                    m_wrap = (m_prev == 255 && m_prev_en == 1 && v == 8'd0) ? 1 : 0;
                end
            end
            m_prev = int'(v);
            m_prev_en = int'(e);
        end
        m_state = (m_faulted != 0) ? 2 : (m_have_base != 0) ? 1 : 0;
    endfunction

    // Drives one sample, lets the edge happen, advances the model, then
    // leaves the caller 1 time unit after the edge for sampling outputs.
    task automatic step(input logic r, input logic c, input logic e, input logic [7:0] v);
        rst = r; clr = c; en = e; cnt = v;
        @(posedge clk);
        model_edge(r, c, e, v);
        #1;
    endtask

    task automatic compare_all(input string tag);
        n_checks++;
        if (err !== 1'(m_err) || wrap !== 1'(m_wrap)) begin
            n_fail++;
            $display("FAIL %s pulses: err=%b wrap=%b expected err=%0d wrap=%0d", tag, err, wrap, m_err, m_wrap);
        end
        n_checks++;
        if (err_cnt !== 8'(m_errs)) begin
            n_fail++;
            $display("FAIL %s err_cnt: got %0d expected %0d", tag, err_cnt, m_errs);
        end
        n_checks++;
        if (state !== 2'(m_state) || fault !== (m_faulted != 0)) begin
            n_fail++;
            $display("FAIL %s state/fault: got %0d/%b expected %0d/%0d", tag, state, fault, m_state, m_faulted);
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h5A);
        n_checks++;
        if ({err, wrap, fault, state, err_cnt} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state: err=%b wrap=%b fault=%b state=%0d err_cnt=%0d expected all 0",
                     err, wrap, fault, state, err_cnt);
        end
    endtask

    task automatic test_count_up();
        for (int i = 0; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'(i));
            n_checks++;
            if (state !== ((i == 0) ? 2'd1 : 2'd1) || err !== 1'b0) begin
                n_fail++;
                $display("FAIL count_up[%0d]: state=%0d err=%b expected state=1 err=0", i, state, err);
            end
        end
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL count_up err_cnt: got %0d expected 0", err_cnt);
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b1, 1'b1, 8'h77);
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap clr->INIT: state=%0d expected 0", state);
        end
        step(1'b1, 1'b0, 1'b1, 8'hFE);
        step(1'b1, 1'b0, 1'b1, 8'hFF);
        compare_all("wrap_pre");
        step(1'b1, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (wrap !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_pulse: wrap=%b err=%b expected wrap=1 err=0", wrap, err);
        end
        step(1'b1, 1'b0, 1'b1, 8'h01);
        n_checks++;
        if (wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_one_cycle: wrap=%b expected 0", wrap);
        end
    endtask

    task automatic test_mismatch();
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h10);
        step(1'b1, 1'b0, 1'b0, 8'h13);
        n_checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL jump_err: err=%b err_cnt=%0d expected err=1 err_cnt=1", err, err_cnt);
        end
        step(1'b1, 1'b0, 1'b0, 8'h13);
        n_checks++;
        if (err !== 1'b0 || err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL rebaseline: err=%b err_cnt=%0d expected err=0 err_cnt=1", err, err_cnt);
        end
    endtask

    task automatic test_fault();
        logic [7:0] bad [4] = '{8'h20, 8'h40, 8'h60, 8'h80};
        step(1'b1, 1'b1, 1'b0, 8'h13);
        step(1'b1, 1'b0, 1'b0, 8'h13);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, bad[i]);
            compare_all("fault_seq");
        end
        n_checks++;
        if (err_cnt !== 8'd4 || fault !== 1'b1 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL fault_entry: err_cnt=%0d fault=%b state=%0d expected 4/1/2", err_cnt, fault, state);
        end
        step(1'b1, 1'b0, 1'b0, 8'h01);
        step(1'b1, 1'b0, 1'b1, 8'hC3);
        n_checks++;
        if (err_cnt !== 8'd4 || err !== 1'b0 || fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_frozen: err_cnt=%0d err=%b fault=%b expected 4/0/1", err_cnt, err, fault);
        end
    endtask

    task automatic test_clear();
        step(1'b1, 1'b1, 1'b0, 8'h99);
        n_checks++;
        if (fault !== 1'b0 || err_cnt !== 8'd0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL clear: fault=%b err_cnt=%0d state=%0d expected 0/0/0", fault, err_cnt, state);
        end
        step(1'b1, 1'b0, 1'b1, 8'h42);
        n_checks++;
        if (err !== 1'b0 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL clear_baseline: err=%b state=%0d expected err=0 state=1", err, state);
        end
        step(1'b1, 1'b0, 1'b0, 8'h43);
        compare_all("after_clear");
    endtask

    task automatic test_saturation();
        logic [7:0] v;
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        v = 8'h00;
        for (int i = 0; i < 256; i++) begin
            v = v + 8'd1;
            step(1'b1, 1'b0, 1'b0, v);   // isolated mismatch
            step(1'b1, 1'b0, 1'b0, v);   // good sample clears the miss run
        end
        n_checks++;
        if (err_cnt !== 8'hFF || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL saturate: err_cnt=%0d fault=%b expected 255/0", err_cnt, fault);
        end
        compare_all("saturate");
        step(1'b1, 1'b0, 1'b0, 8'h55);
        step(1'b1, 1'b0, 1'b0, 8'hAA);
        n_checks++;
        if (err_cnt !== 8'hFF || err !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate_hold: err_cnt=%0d err=%b expected 255/1", err_cnt, err);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 1'b1, 8'h3C);
        n_checks++;
        if ({err, wrap, fault, state, err_cnt} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_mid: err=%b wrap=%b fault=%b state=%0d err_cnt=%0d expected all 0",
                     err, wrap, fault, state, err_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            logic e, c, r;
            logic [7:0] v;
            e = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 299) != 0);
            c = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 24) == 0)
                v = 8'($urandom);
            else if ($urandom_range(0, 199) == 0)
                v = 8'hFD;
            else
                v = 8'((m_prev + m_prev_en) % 256);
            step(r, c, e, v);
            compare_all("random");
            n_checks++;
            if (err === 1'b1 && wrap === 1'b1) begin
                n_fail++;
                $display("FAIL random exclusive: err=%b wrap=%b expected not both 1", err, wrap);
            end
        end
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; en = 1'b0; cnt = 8'h00;
        test_reset();
        test_count_up();
        test_wrap();
        test_mismatch();
        test_fault();
        test_clear();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
